ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) to the keyboard over the shared PS2_CLK/PS2_DATA open-drain pair. It handles the request-to-send sequence, the device-clocked 11-bit frame and the device acknowledge. It sits beside the keyboard receive path on the same pins. That path must ignore the bus while `busy` is high.

---
 rtl/ps2_host_tx.sv | 196 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter
// Request-to-send, device-clocked 11-bit frame and ACK check on open-drain pins.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int SETUP_CYCLES   = 16,
  parameter int START_TIMEOUT  = 1500000,
  parameter int PACKET_TIMEOUT = 200000,
  parameter int FILTER         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DATA
);

  localparam int TMAX_A = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
  localparam int TMAX   = (TMAX_A > START_TIMEOUT) ? TMAX_A : START_TIMEOUT;
  localparam int TW     = $clog2(TMAX + 1);
  localparam int PW     = $clog2(PACKET_TIMEOUT + 1);
  localparam int FW     = $clog2(FILTER + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_SETUP, S_WAIT_CLK, S_SEND, S_RELEASE
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [PW-1:0] pkt_q, pkt_d;
  logic [3:0]    edge_q, edge_d;
  logic [9:0]    frame_q, frame_d;
  logic          ack_q, ack_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic          data_s1_q, data_s1_d, data_s2_q, data_s2_d;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          fall;
  logic          clk_low, data_low;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      pkt_q     <= '0;
      edge_q    <= '0;
      frame_q   <= '0;
      ack_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      data_s1_q <= 1'b1;
      data_s2_q <= 1'b1;
      filt_q    <= 1'b1;
      fcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pkt_q     <= pkt_d;
      edge_q    <= edge_d;
      frame_q   <= frame_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      err_q     <= err_d;
      clk_s1_q  <= clk_s1_d;
      clk_s2_q  <= clk_s2_d;
      data_s1_q <= data_s1_d;
      data_s2_q <= data_s2_d;
      filt_q    <= filt_d;
      fcnt_q    <= fcnt_d;
    end
  end

  // The filtered clock only follows the synchronizer after FILTER stable cycles.
  always_comb begin
    clk_s1_d  = PS2_CLK;
    clk_s2_d  = clk_s1_q;
    data_s1_d = PS2_DATA;
    data_s2_d = data_s1_q;
    filt_d    = filt_q;
    fcnt_d    = '0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == FW'(FILTER - 1)) begin
        filt_d = clk_s2_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
    fall = filt_q & ~filt_d;
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pkt_d   = pkt_q;
    edge_d  = edge_q;
    frame_d = frame_q;
    ack_d   = ack_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tx_start) begin
          frame_d = {1'b1, ~^tx_data, tx_data};
          timer_d = '0;
          pkt_d   = '0;
          edge_d  = '0;
          ack_d   = 1'b0;
          state_d = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (timer_q == TW'(INHIBIT_CYCLES - 1)) begin
          timer_d = '0;
          state_d = S_SETUP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_SETUP: begin
        if (timer_q == TW'(SETUP_CYCLES - 1)) begin
          timer_d = '0;
          state_d = S_WAIT_CLK;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_WAIT_CLK: begin
        if (fall) begin
          edge_d  = 4'd1;
          pkt_d   = '0;
          state_d = S_SEND;
        end else if (timer_q == TW'(START_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_SEND: begin
        if (pkt_q == PW'(PACKET_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          pkt_d = pkt_q + 1'b1;
          if (fall) begin
            if (edge_q == 4'd10) begin
              ack_d   = ~data_s2_q;
              state_d = S_RELEASE;
            end else begin
              edge_d = edge_q + 1'b1;
            end
          end
        end
      end
      S_RELEASE: begin
        if (pkt_q == PW'(PACKET_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          pkt_d = pkt_q + 1'b1;
          if (filt_q) begin
            done_d  = ack_q;
            err_d   = ~ack_q;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Edge n presents frame bit n-1; frame bit 9 is the stop bit, i.e. released.
  always_comb begin
    clk_low  = (state_q == S_INHIBIT) || (state_q == S_SETUP);
    data_low = 1'b0;
    if ((state_q == S_SETUP) || (state_q == S_WAIT_CLK)) begin
      data_low = 1'b1;
    end else if ((state_q == S_SEND) && (edge_q >= 4'd1) && (edge_q <= 4'd10)) begin
      data_low = ~frame_q[edge_q - 4'd1];
    end
    busy    = (state_q != S_IDLE);
    tx_done = done_q;
    tx_err  = err_q;
  end

  assign PS2_CLK  = clk_low  ? 1'b0 : 1'bz;
  assign PS2_DATA = data_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - bench for ps2_host_tx with a PS/2 keyboard device model
// Vector table, randomized frames against a frame model, and corner sequences.
module tb_ps2_host_tx;

  localparam int I  = 40;
  localparam int S  = 6;
  localparam int ST = 300;
  localparam int PT = 2000;
  localparam int F  = 4;
  localparam int H  = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       busy, tx_done, tx_err;
  wire        ps2_clk, ps2_data;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  assign ps2_clk  = dev_clk_low  ? 1'b0 : 1'bz;
  assign ps2_data = dev_data_low ? 1'b0 : 1'bz;
  pullup (ps2_clk);
  pullup (ps2_data);

  ps2_host_tx #(
    .INHIBIT_CYCLES(I), .SETUP_CYCLES(S), .START_TIMEOUT(ST),
    .PACKET_TIMEOUT(PT), .FILTER(F)
  ) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_start(tx_start),
    .busy(busy), .tx_done(tx_done), .tx_err(tx_err),
    .PS2_CLK(ps2_clk), .PS2_DATA(ps2_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_done) done_cnt++;
    if (tx_err) err_cnt++;
    if (tx_done && tx_err) both_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] data;
    logic       ack;
    logic       par;
    int         done;
    int         err;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [10:0] model_frame(input logic [7:0] d);
    logic [10:0] f;
    int ones;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = ((d >> i) & 8'd1) != 0;
      ones += ((d >> i) & 8'd1);
    end
    f[9]  = (ones % 2) == 0;
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic start_tx(input logic [7:0] d);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  // Device side: waits for the host to release PS2_CLK, then clocks 11 bits.
  task automatic device_frame(input logic ack, input int glitch_at, input int abort_at,
                              input logic chain, input logic [7:0] chain_data,
                              output logic [10:0] seen, output int low_cycles,
                              output int data_low_at, output int got_done, output int got_err);
    int k;
    seen = '1; got_done = 0; got_err = 0; data_low_at = -1;
    k = 0;
    while (ps2_clk === 1'b0 && k < I + S + 50) begin
      if (ps2_data === 1'b0 && data_low_at < 0) data_low_at = k;
      k++;
      @(negedge clk);
    end
    low_cycles = k;
    seen[0] = ps2_data;
    for (int e = 1; e <= 11; e++) begin
      if (e == 11 && ack) dev_data_low = 1'b1;
      cycles(H);
      dev_clk_low = 1'b1;
      cycles(H);
      dev_clk_low = 1'b0;
      if (e <= 10) seen[e] = ps2_data;
      if (e == glitch_at) begin
        cycles(10);
        dev_clk_low = 1'b1;
        cycles(3);
        dev_clk_low = 1'b0;
      end
      if (e == abort_at) begin
        cycles(3);
        check("abort_pre_data", ps2_data, 0);
        #2 rst = 1'b0;
        #1;
        check("abort_clk_released", ps2_clk, 1);
        check("abort_data_released", ps2_data, 1);
        check("abort_busy", busy, 0);
        check("abort_done", tx_done, 0);
        check("abort_err", tx_err, 0);
        return;
      end
    end
    dev_data_low = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (tx_done) got_done++;
      if (tx_err) got_err++;
      if (tx_done || tx_err) begin
        if (chain) begin
          tx_data  = chain_data;
          tx_start = 1'b1;
          @(negedge clk);
          tx_start = 1'b0;
          return;
        end
        for (int j = 0; j < 5; j++) begin
          @(negedge clk);
          if (tx_done) got_done++;
          if (tx_err) got_err++;
        end
        return;
      end
    end
  endtask

  initial begin
    logic [10:0] seen;
    int low, dlow, gd, ge, k, pre, d0;
    logic [7:0] d;
    logic a;

    vecs[0] = '{8'hED, 1'b1, 1'b1, 1, 0};
    vecs[1] = '{8'hA5, 1'b0, 1'b1, 0, 1};
    vecs[2] = '{8'h80, 1'b1, 1'b0, 1, 0};
    vecs[3] = '{8'h3C, 1'b1, 1'b1, 1, 0};
    vecs[4] = '{8'h01, 1'b0, 1'b0, 0, 1};

    cycles(3);
    check("reset_busy", busy, 0);
    check("reset_done", tx_done, 0);
    check("reset_err", tx_err, 0);
    check("reset_clk_line", ps2_clk, 1);
    check("reset_data_line", ps2_data, 1);
    rst = 1'b1;
    cycles(F + 4);

    foreach (vecs[v]) begin
      start_tx(vecs[v].data);
      check("vec_busy", busy, 1);
      device_frame(vecs[v].ack, -1, -1, 1'b0, 8'h00, seen, low, dlow, gd, ge);
      check("vec_clk_low", low, I + S);
      check("vec_data_low_at", dlow, I);
      check("vec_start", seen[0], 0);
      check("vec_data", seen[8:1], vecs[v].data);
      check("vec_parity", seen[9], vecs[v].par);
      check("vec_stop", seen[10], 1);
      check("vec_done", gd, vecs[v].done);
      check("vec_err", ge, vecs[v].err);
      check("vec_busy_after", busy, 0);
      cycles(5);
    end

    start_tx(8'hF4);
    device_frame(1'b1, -1, -1, 1'b1, 8'h00, seen, low, dlow, gd, ge);
    check("b2b_first_parity", seen[9], 0);
    check("b2b_first_done", gd, 1);
    check("b2b_second_accepted", busy, 1);
    device_frame(1'b1, -1, -1, 1'b0, 8'h00, seen, low, dlow, gd, ge);
    check("b2b_second_clk_low", low, I + S);
    check("b2b_second_data", seen[8:1], 8'h00);
    check("b2b_second_parity", seen[9], 1);
    check("b2b_second_done", gd, 1);
    cycles(5);

    start_tx(8'h5A);
    device_frame(1'b1, 3, -1, 1'b0, 8'h00, seen, low, dlow, gd, ge);
    check("glitch_frame", seen, 11'b11_0101_1010_0);
    check("glitch_done", gd, 1);
    cycles(5);

    #1 d0 = done_cnt;
    @(negedge clk);
    start_tx(8'h5A);
    k = 0;
    while (!tx_err && k < I + S + ST + 20) begin
      @(negedge clk);
      k++;
    end
    check("timeout_latency", k, I + S + ST);
    check("timeout_clk_released", ps2_clk, 1);
    check("timeout_data_released", ps2_data, 1);
    check("timeout_busy", busy, 0);
    cycles(3);
    #1 check("timeout_no_done", done_cnt - d0, 0);
    @(negedge clk);

    start_tx(8'h00);
    device_frame(1'b1, -1, 4, 1'b0, 8'h00, seen, low, dlow, gd, ge);
    cycles(2);
    rst = 1'b1;
    cycles(F + 4);
    start_tx(8'hFF);
    device_frame(1'b1, -1, -1, 1'b0, 8'h00, seen, low, dlow, gd, ge);
    check("post_reset_data", seen[8:1], 8'hFF);
    check("post_reset_parity", seen[9], 1);
    check("post_reset_done", gd, 1);
    cycles(5);

    for (int r = 0; r < 6; r++) begin
      d = 8'($urandom);
      a = ($urandom % 4) != 0;
      pre = $urandom_range(0, 5);
      start_tx(d);
      tx_data = 8'($urandom);
      if (pre > 0) begin
        tx_start = 1'b1;
        cycles(pre);
        tx_start = 1'b0;
      end
      device_frame(a, -1, -1, 1'b0, 8'h00, seen, low, dlow, gd, ge);
      check("rand_clk_low", low + pre, I + S);
      check("rand_frame", seen, model_frame(d));
      check("rand_done", gd, a ? 1 : 0);
      check("rand_err", ge, a ? 0 : 1);
      cycles($urandom_range(1, 8));
    end

    #1 check("never_done_and_err", both_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
